// File: rtl/contador_bcd_mux.sv
// Four-digit BCD up/down counter with synchronous load and a multiplexed
// 7-segment scan that blanks leading zeros.
module contador_bcd_mux #(
   parameter int unsigned SCAN_DIV = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        habilita,
   input  logic        sentido,
   input  logic        carrega,
   input  logic [15:0] valor_carga,
   output logic [15:0] contagem,
   output logic [3:0]  saida_digito,
   output logic [3:0]  seleciona,
   output logic        apaga,
   output logic        estouro
);

   localparam logic [15:0] DIV_MAX = 16'(SCAN_DIV - 1);

   logic [15:0] cont_q, cont_d;
   logic        estouro_q, estouro_d;
   logic [15:0] div_q, div_d;
   logic [1:0]  idx_q, idx_d;
   logic        carry;
   logic [3:0]  nib;

   // Count next state: load clamps each nibble; a step ripples carry/borrow
   // through all four digits, and a carry out of the top digit is a wrap.
   always_comb begin
      cont_d    = cont_q;
      estouro_d = 1'b0;
      carry     = 1'b0;
      nib       = 4'd0;
      if (carrega) begin
         for (int i = 0; i < 4; i++) begin
            nib = valor_carga[4*i +: 4];
            cont_d[4*i +: 4] = (nib > 4'd9) ? 4'd0 : nib;
         end
      end else if (habilita) begin
         carry = 1'b1;
         for (int i = 0; i < 4; i++) begin
            nib = cont_q[4*i +: 4];
            if (carry) begin
               if (sentido) begin
                  if (nib == 4'd9) begin
                     nib = 4'd0;
                  end else begin
                     nib   = nib + 4'd1;
                     carry = 1'b0;
                  end
               end else begin
                  if (nib == 4'd0) begin
                     nib = 4'd9;
                  end else begin
                     nib   = nib - 4'd1;
                     carry = 1'b0;
                  end
               end
            end
            cont_d[4*i +: 4] = nib;
         end
         estouro_d = carry;
      end
   end

   always_comb begin
      div_d = div_q + 16'd1;
      idx_d = idx_q;
      if (div_q == DIV_MAX) begin
         div_d = 16'd0;
         idx_d = idx_q + 2'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cont_q    <= 16'h0000;
         estouro_q <= 1'b0;
         div_q     <= 16'd0;
         idx_q     <= 2'd0;
      end else begin
         cont_q    <= cont_d;
         estouro_q <= estouro_d;
         div_q     <= div_d;
         idx_q     <= idx_d;
      end
   end

   assign contagem     = cont_q;
   assign estouro      = estouro_q;
   assign saida_digito = cont_q[{idx_q, 2'b00} +: 4];
   assign seleciona    = 4'b0001 << idx_q;

   // Blank when the scanned digit and every digit above it are zero.
   always_comb begin
      apaga = (idx_q != 2'd0);
      for (int i = 0; i < 4; i++) begin
         if (i >= int'(idx_q) && cont_q[4*i +: 4] != 4'd0) begin
            apaga = 1'b0;
         end
      end
   end

endmodule
